// File: rtl/seg_disp_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment display block:
// FSM state encoding and segment patterns in {g,f,e,d,c,b,a} order.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high segment pattern; non-decimal codes
// show a dash so a corrupted digit is visible on the board.
module seg7_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bin_to_seg_display.sv
// Sequential shift-add-3 binary-to-BCD converter feeding a free-running,
// time-multiplexed seven-segment digit scanner with optional leading-zero blanking.
module bin_to_seg_display
  import seg_disp_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_LZ    = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                state_reg;
  logic [BIN_W-1:0]      bin_work_reg;
  logic [4*DIGITS-1:0]   bcd_work_reg;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_out_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  ovf_work_reg;
  logic                  ovf_out_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [SCAN_W-1:0]     prescale_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic [6:0]            seg_reg;
  logic [DIGITS-1:0]     dig_en_reg;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_next;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_work_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_work_reg[4*gi +: 4] + 4'd3 :
                                  bcd_work_reg[4*gi +: 4];
      // Digit gi is a leading zero when it and every digit above it are zero.
      if (gi == 0) begin : g_lsd
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = ~|bcd_out_reg[4*DIGITS-1:4*gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      bin_work_reg <= '0;
      bcd_work_reg <= '0;
      bcd_out_reg  <= '0;
      cnt_reg      <= '0;
      ovf_work_reg <= 1'b0;
      ovf_out_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load) begin
            bin_work_reg <= bin_in;
            bcd_work_reg <= '0;
            ovf_work_reg <= 1'b0;
            cnt_reg      <= CNT_W'(BIN_W);
            busy_reg     <= 1'b1;
            state_reg    <= ST_CONV;
          end
        end
        ST_CONV: begin
          // A bit leaving the top digit means the value exceeds the display range.
          bcd_work_reg <= {bcd_adj[4*DIGITS-2:0], bin_work_reg[BIN_W-1]};
          bin_work_reg <= bin_work_reg << 1;
          ovf_work_reg <= ovf_work_reg | bcd_adj[4*DIGITS-1];
          cnt_reg      <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_out_reg <= bcd_work_reg;
          ovf_out_reg <= ovf_work_reg;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cur_digit = bcd_out_reg[4*scan_idx_reg +: 4];

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  assign seg_next = ((BLANK_LZ != 0) && lz_mask[scan_idx_reg]) ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_reg <= '0;
      scan_idx_reg <= '0;
      seg_reg      <= SEG_0;
      dig_en_reg   <= DIGITS'(1);
    end else begin
      if (prescale_reg == SCAN_W'(SCAN_DIV - 1)) begin
        prescale_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_reg + IDX_W'(1);
      end else begin
        prescale_reg <= prescale_reg + SCAN_W'(1);
      end
      seg_reg    <= seg_next;
      dig_en_reg <= DIGITS'(1) << scan_idx_reg;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd_out  = bcd_out_reg;
  assign overflow = ovf_out_reg;
  assign seg      = (SEG_ACT_LOW != 0) ? ~seg_reg : seg_reg;
  assign dig_en   = (SEG_ACT_LOW != 0) ? ~dig_en_reg : dig_en_reg;

endmodule

// File: tb/tb_bin_to_seg_display.sv
// Directed bench: three instances (3-digit, 2-digit, 3-digit active-low) share
// stimulus; each instance is checked against hand-computed values.
module tb_bin_to_seg_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bin_in = 8'd0;
  logic        load = 1'b0;

  logic        busy1, done1, ovf1;
  logic [11:0] bcd1;
  logic [6:0]  seg1;
  logic [2:0]  dig1;

  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [6:0]  seg2;
  logic [1:0]  dig2;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [6:0]  seg3;
  logic [2:0]  dig3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_seg_display #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1), .SEG_ACT_LOW(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .busy(busy1), .done(done1),
    .bcd_out(bcd1), .overflow(ovf1), .seg(seg1), .dig_en(dig1));

  bin_to_seg_display #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1), .SEG_ACT_LOW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .busy(busy2), .done(done2),
    .bcd_out(bcd2), .overflow(ovf2), .seg(seg2), .dig_en(dig2));

  bin_to_seg_display #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1), .SEG_ACT_LOW(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .busy(busy3), .done(done3),
    .bcd_out(bcd3), .overflow(ovf3), .seg(seg3), .dig_en(dig3));

  // Drives one load and tracks busy/done; optionally pulses a second load at loop step extra_at.
  task automatic run_load(input logic [7:0] v, input int extra_at, input logic [7:0] extra_v,
                          output int bcyc, output int dcnt, output bit tmo);
    @(negedge clk);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcyc = 0;
    dcnt = 0;
    tmo  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy1) bcyc++;
      if (done1) dcnt++;
      if (!busy1) begin
        tmo = 1'b0;
        break;
      end
      if (i == extra_at) begin
        bin_in = extra_v;
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done1) dcnt++;
    end
    $display("load %0d: busy %0d cycles, done %0d pulses, bcd=%h ovf=%0d", v, bcyc, dcnt, bcd1, ovf1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, ovf1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {busy1, done1, ovf1});
    end
    n_checks++;
    if (bcd1 !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bcd: got %h expected 000", bcd1);
    end
    n_checks++;
    if (dig1 !== 3'b001 || seg1 !== 7'h3F) begin
      n_fail++;
      $display("FAIL reset_scan: got dig=%b seg=%h expected dig=001 seg=3f", dig1, seg1);
    end
    n_checks++;
    if (dig3 !== 3'b110 || seg3 !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_scan_actlow: got dig=%b seg=%h expected dig=110 seg=40", dig3, seg3);
    end
    rst_n = 1'b1;
    $display("reset: dig=%b seg=%h bcd=%h", dig1, seg1, bcd1);
  endtask

  task automatic test_scan_digits(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] exp_seg;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (dig1)
        3'b001:  exp_seg = e0;
        3'b010:  exp_seg = e1;
        3'b100:  exp_seg = e2;
        default: exp_seg = 7'h7F;
      endcase
      n_checks++;
      if (seg1 !== exp_seg || !(dig1 inside {3'b001, 3'b010, 3'b100})) begin
        n_fail++;
        $display("FAIL scan_seg: dig=%b got seg=%h expected %h", dig1, seg1, exp_seg);
      end
      n_checks++;
      if (seg3 !== ~exp_seg) begin
        n_fail++;
        $display("FAIL scan_seg_actlow: dig=%b got seg=%h expected %h", dig1, seg3, ~exp_seg);
      end
    end
    $display("scan check: expected digits %h %h %h", e2, e1, e0);
  endtask

  task automatic test_load_max;
    int bc, dc;
    bit to;
    run_load(8'd255, -1, 8'd0, bc, dc, to);
    n_checks++;
    if (to || bc != 9) begin
      n_fail++;
      $display("FAIL max_busy: got %0d cycles (timeout=%0d) expected 9", bc, to);
    end
    n_checks++;
    if (dc != 1) begin
      n_fail++;
      $display("FAIL max_done: got %0d pulses expected 1", dc);
    end
    n_checks++;
    if (bcd1 !== 12'h255 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL max_bcd: got %h ovf=%0d expected 255 ovf=0", bcd1, ovf1);
    end
    test_scan_digits(7'h6D, 7'h6D, 7'h5B);
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    bin_in = 8'd99;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %0d expected 1", busy1);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy1, done1, ovf1} !== 3'b000 || bcd1 !== 12'h000) begin
      n_fail++;
      $display("FAIL midrun_reset: got flags=%b bcd=%h expected 000 000", {busy1, done1, ovf1}, bcd1);
    end
    n_checks++;
    if (dig1 !== 3'b001 || seg1 !== 7'h3F) begin
      n_fail++;
      $display("FAIL midrun_scan: got dig=%b seg=%h expected 001 3f", dig1, seg1);
    end
    $display("reset mid-run: busy=%0d bcd=%h dig=%b seg=%h", busy1, bcd1, dig1, seg1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_zero;
    int bc, dc;
    bit to;
    run_load(8'd0, -1, 8'd0, bc, dc, to);
    n_checks++;
    if (to || bc != 9 || dc != 1 || bcd1 !== 12'h000) begin
      n_fail++;
      $display("FAIL zero_load: got busy=%0d done=%0d bcd=%h expected 9 1 000", bc, dc, bcd1);
    end
    test_scan_digits(7'h3F, 7'h00, 7'h00);
  endtask

  task automatic test_ignored_load;
    int bc, dc;
    bit to;
    run_load(8'd200, 1, 8'd17, bc, dc, to);
    n_checks++;
    if (to || bc != 9 || dc != 1) begin
      n_fail++;
      $display("FAIL ignore_timing: got busy=%0d done=%0d expected 9 1", bc, dc);
    end
    n_checks++;
    if (bcd1 !== 12'h200 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_bcd: got %h busy=%0d expected 200 busy=0", bcd1, busy1);
    end
    test_scan_digits(7'h3F, 7'h3F, 7'h5B);
  endtask

  task automatic test_two_digits;
    int bc, dc;
    bit to;
    run_load(8'd123, -1, 8'd0, bc, dc, to);
    n_checks++;
    if (bcd2 !== 8'h23 || ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL d2_overflow: got %h ovf=%0d expected 23 ovf=1", bcd2, ovf2);
    end
    n_checks++;
    if (bcd1 !== 12'h123 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL d3_123: got %h ovf=%0d expected 123 ovf=0", bcd1, ovf1);
    end
    run_load(8'd45, -1, 8'd0, bc, dc, to);
    n_checks++;
    if (bcd2 !== 8'h45 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL d2_clear: got %h ovf=%0d expected 45 ovf=0", bcd2, ovf2);
    end
    test_scan_digits(7'h6D, 7'h66, 7'h00);
  endtask

  task automatic test_idle_scan;
    logic [2:0] seq3 [4];
    logic [1:0] seq2 [4];
    logic [2:0] e3;
    logic [1:0] e2;
    seq3[0] = 3'b001; seq3[1] = 3'b010; seq3[2] = 3'b100; seq3[3] = 3'b001;
    seq2[0] = 2'b01;  seq2[1] = 2'b10;  seq2[2] = 2'b01;  seq2[3] = 2'b10;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      e3 = seq3[(e - 1) / 4];
      e2 = seq2[(e - 1) / 4];
      n_checks++;
      if (dig1 !== e3 || dig3 !== ~e3) begin
        n_fail++;
        $display("FAIL idle_scan edge %0d: got dig=%b dig_actlow=%b expected %b", e, dig1, dig3, e3);
      end
      n_checks++;
      if (dig2 !== e2) begin
        n_fail++;
        $display("FAIL idle_scan2 edge %0d: got dig=%b expected %b", e, dig2, e2);
      end
    end
    $display("idle scan: 16 edges checked");
  endtask

  initial begin
    test_reset();
    test_load_max();
    test_reset_midrun();
    test_load_zero();
    test_ignored_load();
    test_two_digits();
    test_idle_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
